// File: rtl/conv_pkg.sv
// conv_pkg: shared FSM state type and limits for the
// convolution MAC issue sequencer.
package conv_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } state_t;

  localparam int MAC_LATENCY = 7;
  localparam int KMAX        = 7;

endpackage

// File: rtl/conv_flag_delay.sv
// conv_flag_delay: DEPTH-stage shift of the {nop,last} issue
// flags, aligned with the MAC pipe. Ports: clk, aclr_n, nop_in,
// last_in in; nop_out, last_out out (oldest stage).
module conv_flag_delay #(
  parameter int DEPTH = 7
) (
  input  logic clk,
  input  logic aclr_n,
  input  logic nop_in,
  input  logic last_in,
  output logic nop_out,
  output logic last_out
);

  logic [DEPTH-1:0] nop_sr;
  logic [DEPTH-1:0] last_sr;

  always_ff @(posedge clk) begin
    if (!aclr_n) begin
      nop_sr  <= '1;
      last_sr <= '0;
    end else begin
      nop_sr[0]  <= nop_in;
      last_sr[0] <= last_in;
      for (int i = 1; i < DEPTH; i++) begin
        nop_sr[i]  <= nop_sr[i-1];
        last_sr[i] <= last_sr[i-1];
      end
    end
  end

  assign nop_out  = nop_sr[DEPTH-1];
  assign last_out = last_sr[DEPTH-1];

endmodule

// File: rtl/conv_mac_sequencer.sv
// conv_mac_sequencer: walks output pixels and kernel taps of a
// valid-padding convolution, issuing one operand pair per cycle
// (NOP when src_valid=0), tracks last taps through the MAC
// latency and pulses done after the pipe drains.
// Ports: clk, aclr_n (sync, active-low), start, img_w, img_h,
// ker_k, src_valid in; issue_nop/first/last, pix_addr,
// ker_addr, out_valid, out_index, busy, done, cfg_err out.
module conv_mac_sequencer
  import conv_pkg::*;
#(
  parameter int LATENCY = MAC_LATENCY,
  parameter int ADDR_W  = 12,
  parameter int DIM_W   = 6
) (
  input  logic              clk,
  input  logic              aclr_n,
  input  logic              start,
  input  logic [DIM_W-1:0]  img_w,
  input  logic [DIM_W-1:0]  img_h,
  input  logic [2:0]        ker_k,
  input  logic              src_valid,
  output logic              issue_nop,
  output logic              issue_first,
  output logic              issue_last,
  output logic [ADDR_W-1:0] pix_addr,
  output logic [5:0]        ker_addr,
  output logic              out_valid,
  output logic [ADDR_W-1:0] out_index,
  output logic              busy,
  output logic              done,
  output logic              cfg_err
);

  localparam int CW =
    (LATENCY > 1) ? $clog2(LATENCY) : 1;

  state_t state, state_d;

  logic [DIM_W-1:0]  lim_x, lim_y;
  logic [ADDR_W-1:0] w_a;
  logic [2:0]        km1;

  logic [2:0]        kx, ky, kx_n, ky_n;
  logic [DIM_W-1:0]  ox, oy, ox_n, oy_n;
  // rb = (oy+ky)*W, oyb = oy*W; kept incrementally
  logic [ADDR_W-1:0] rb, oyb, rb_n, oyb_n;
  logic [ADDR_W-1:0] pix_n;
  logic [5:0]        ker_n;
  logic [CW-1:0]     dcnt;

  logic [DIM_W-1:0]  kext;
  logic              cfg_bad;
  logic              fire;
  logic              kx_end, ky_end, ox_end, oy_end;
  logic              tap_end, pix_end;
  logic              dl_nop, dl_last;

  assign kext    = DIM_W'(ker_k);
  assign cfg_bad = (ker_k == 3'd0)
                || (ker_k > 3'(KMAX))
                || (kext > img_w)
                || (kext > img_h);

  assign fire    = (state == ISSUE) && src_valid;
  assign kx_end  = (kx == km1);
  assign ky_end  = (ky == km1);
  assign ox_end  = (ox == lim_x);
  assign oy_end  = (oy == lim_y);
  assign tap_end = kx_end && ky_end;
  assign pix_end = tap_end && ox_end && oy_end;

  assign issue_nop   = !fire;
  assign issue_first = fire && (kx == 3'd0)
                    && (ky == 3'd0);
  assign issue_last  = fire && tap_end;

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_ff @(posedge clk) begin
    if (!aclr_n) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_d = cfg_bad ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        if (fire && pix_end) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (dcnt == CW'(LATENCY - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // tap carry chain: kx -> ky -> ox -> oy
  always_comb begin
    kx_n  = kx;
    ky_n  = ky;
    ox_n  = ox;
    oy_n  = oy;
    rb_n  = rb;
    oyb_n = oyb;
    unique case (1'b1)
      !kx_end: begin
        kx_n = kx + 3'd1;
      end
      kx_end && !ky_end: begin
        kx_n = 3'd0;
        ky_n = ky + 3'd1;
        rb_n = rb + w_a;
      end
      tap_end && !ox_end: begin
        kx_n = 3'd0;
        ky_n = 3'd0;
        ox_n = ox + DIM_W'(1);
        rb_n = oyb;
      end
      default: begin
        kx_n  = 3'd0;
        ky_n  = 3'd0;
        ox_n  = '0;
        oy_n  = oy + DIM_W'(1);
        oyb_n = oyb + w_a;
        rb_n  = oyb + w_a;
      end
    endcase
    pix_n = rb_n
          + ADDR_W'(ox_n)
          + ADDR_W'(kx_n);
    ker_n = tap_end ? 6'd0 : ker_addr + 6'd1;
  end

  always_ff @(posedge clk) begin
    if (!aclr_n) begin
      lim_x     <= '0;
      lim_y     <= '0;
      w_a       <= '0;
      km1       <= '0;
      kx        <= '0;
      ky        <= '0;
      ox        <= '0;
      oy        <= '0;
      rb        <= '0;
      oyb       <= '0;
      pix_addr  <= '0;
      ker_addr  <= '0;
      out_index <= '0;
      cfg_err   <= 1'b0;
      dcnt      <= '0;
    end else begin
      if (state == IDLE && start) begin
        lim_x     <= img_w - kext;
        lim_y     <= img_h - kext;
        w_a       <= ADDR_W'(img_w);
        km1       <= ker_k - 3'd1;
        kx        <= '0;
        ky        <= '0;
        ox        <= '0;
        oy        <= '0;
        rb        <= '0;
        oyb       <= '0;
        pix_addr  <= '0;
        ker_addr  <= '0;
        out_index <= '0;
        cfg_err   <= cfg_bad;
      end else begin
        if (fire) begin
          kx       <= kx_n;
          ky       <= ky_n;
          ox       <= ox_n;
          oy       <= oy_n;
          rb       <= rb_n;
          oyb      <= oyb_n;
          pix_addr <= pix_n;
          ker_addr <= ker_n;
        end
        if (out_valid) begin
          out_index <= out_index + ADDR_W'(1);
        end
      end
      dcnt <= (state == DRAIN) ? dcnt + CW'(1) : '0;
    end
  end

  conv_flag_delay #(
    .DEPTH (LATENCY)
  ) u_dly (
    .clk      (clk),
    .aclr_n   (aclr_n),
    .nop_in   (issue_nop),
    .last_in  (issue_last),
    .nop_out  (dl_nop),
    .last_out (dl_last)
  );

  assign out_valid = dl_last && !dl_nop;

endmodule
